// File: rtl/ctrl_fmem_conv_sched_if.sv
// Port bundle for the convolution job sequencer: filter stream, fmem write port,
// xmem/output-controller handshake and status.
interface ctrl_fmem_conv_sched_if #(
    parameter int F_MEM_ADDR_WIDTH = 5,
    parameter int CONV_CNT_WIDTH   = 16
);
    // Coefficient stream: a beat transfers on a rising clk edge where f_valid && f_ready;
    // the sender holds f_valid without regard to f_ready, and ready never depends on valid.
    logic                        f_valid;
    logic                        f_ready;
    logic                        load_new_f;
    logic                        xmem_full;
    logic                        conv_done;
    logic                        fmem_wr_en;
    logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr;
    logic                        conv_start;
    logic                        f_loaded;
    logic                        busy;
    logic [CONV_CNT_WIDTH-1:0]   conv_count;
    logic                        proto_err;
    logic [2:0]                  state_dbg;

    modport master (
        output f_valid, load_new_f, xmem_full, conv_done,
        input  f_ready, fmem_wr_en, fmem_addr, conv_start, f_loaded, busy,
               conv_count, proto_err, state_dbg
    );

    modport slave (
        input  f_valid, load_new_f, xmem_full, conv_done,
        output f_ready, fmem_wr_en, fmem_addr, conv_start, f_loaded, busy,
               conv_count, proto_err, state_dbg
    );
endinterface

// File: rtl/ctrl_fmem_conv_sched.sv
// Job sequencer: loads the filter into fmem, fires conv_start whenever x memory is full,
// waits for conv_done, then reuses or reloads the filter. Counts completed jobs.
module ctrl_fmem_conv_sched #(
    parameter int F_SIZE           = 32,
    parameter int F_MEM_ADDR_WIDTH = 5,
    parameter int CONV_CNT_WIDTH   = 16
) (
    input logic                   clk,
    input logic                   reset,
    ctrl_fmem_conv_sched_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_F = 3'd1;
    localparam logic [2:0] WAIT_X = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] NEXT   = 3'd5;

    localparam logic [F_MEM_ADDR_WIDTH-1:0] LAST_ADDR = F_MEM_ADDR_WIDTH'(F_SIZE - 1);

    logic [2:0]                  state;
    logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr;
    logic                        conv_start;
    logic                        f_loaded;
    logic [CONV_CNT_WIDTH-1:0]   conv_count;
    logic                        proto_err;
    logic                        f_ready;
    logic                        wr_en;

    assign f_ready = (state == LOAD_F);
    assign wr_en   = bus.f_valid & f_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fmem_addr  <= '0;
            conv_start <= 1'b0;
            f_loaded   <= 1'b0;
            conv_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            // A completion pulse outside RUN is a protocol violation; it is latched, not acted on.
            if (bus.conv_done && state != RUN)
                proto_err <= 1'b1;

            case (state)
                IDLE: state <= LOAD_F;
                LOAD_F: begin
                    if (wr_en) begin
                        if (fmem_addr == LAST_ADDR) begin
                            fmem_addr <= '0;
                            f_loaded  <= 1'b1;
                            state     <= WAIT_X;
                        end else begin
                            fmem_addr <= fmem_addr + 1'b1;
                        end
                    end
                end
                WAIT_X: begin
                    if (bus.xmem_full) begin
                        conv_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: state <= RUN;
                RUN: begin
                    if (bus.conv_done) begin
                        if (!(&conv_count))
                            conv_count <= conv_count + 1'b1;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (bus.load_new_f) begin
                        f_loaded  <= 1'b0;
                        fmem_addr <= '0;
                        state     <= LOAD_F;
                    end else begin
                        state <= WAIT_X;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.f_ready    = f_ready;
    assign bus.fmem_wr_en = wr_en;
    assign bus.fmem_addr  = fmem_addr;
    assign bus.conv_start = conv_start;
    assign bus.f_loaded   = f_loaded;
    assign bus.busy       = (state == START) || (state == RUN);
    assign bus.conv_count = conv_count;
    assign bus.proto_err  = proto_err;
    assign bus.state_dbg  = state;
endmodule
